// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read controller for the synchronous FIFO
// Pops bursts of BURST_L words (or a short burst after TIMEOUT) onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 4,
  parameter int BURST_L = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic [ADDR_W:0]   fifo_count,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [ADDR_W:0] BURST_V   = (ADDR_W + 1)'(BURST_L);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t              state, state_next;
  logic [TW-1:0]       timer;
  logic [ADDR_W:0]     remaining;
  logic                inflight;
  logic                inflight_last;
  logic [DATA_W-1:0]   buf_data [2];
  logic [1:0]          buf_last;
  logic                rd_ptr, wr_ptr;
  logic [1:0]          occ;
  logic                pop, push;
  logic                start_full, start_short, partial;
  logic [2:0]          slots_used;

  assign pop        = m_valid & m_ready;
  assign push       = inflight;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = buf_data[rd_ptr];
  assign m_last     = m_valid & buf_last[rd_ptr];
  assign busy       = (state != IDLE);

  // Slots the buffer will hold after this edge, counting the word still in flight.
  assign slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = n_reset & (state == BURST) & (remaining != '0) & ~fifo_empty
                      & (slots_used < 3'd2);

  assign start_full  = (fifo_count >= BURST_V);
  assign partial     = (fifo_count != '0) && !start_full;
  assign start_short = partial && (timer == TIMEOUT_V);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_full || start_short) state_next = BURST;
      BURST:   if (fifo_rd_en && (remaining == ONE)) state_next = DRAIN;
      DRAIN:   if ((occ == 2'd0) && !inflight) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state         <= IDLE;
      timer         <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_last      <= 2'b00;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= 2'd0;
      err           <= 1'b0;
    end else begin
      state <= state_next;

      if ((state != IDLE) || !partial || start_short)
        timer <= '0;
      else if (timer != TIMEOUT_V)
        timer <= timer + TW'(1);

      if (state == IDLE) begin
        if (start_full)
          remaining <= BURST_V;
        else if (start_short)
          remaining <= fifo_count;
      end else if (fifo_rd_en) begin
        remaining <= remaining - ONE;
      end

      // The last tag is decided at issue time and travels with the read.
      inflight <= fifo_rd_en;
      if (fifo_rd_en)
        inflight_last <= (remaining == ONE);

      if (push) begin
        buf_data[wr_ptr] <= fifo_data;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};

      if (fifo_rd_en && fifo_empty)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader
// A behavioural FIFO feeds the DUT; a forked monitor checks every streamed word.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [23:0] fifo_data = '0;
  logic [4:0]  fifo_count = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [23:0] wr_words [64];
  int          wr_req    = 0;
  int          wr_done   = 0;
  int          drop_req  = 0;
  int          drop_done = 0;
  logic [23:0] fq [$];

  logic [23:0] exp_data [64];
  logic        exp_last [64];
  int          exp_wr = 0;
  int          exp_rd = 0;

  fifo_burst_reader #(
    .DATA_W (24),
    .ADDR_W (4),
    .BURST_L(4),
    .TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .fifo_data (fifo_data),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, count and empty; reads, then drops, then writes.
  always @(posedge clk) begin
    logic [23:0] w;
    if (fifo_rd_en && (fq.size() > 0)) begin
      w = fq.pop_front();
      fifo_data <= w;
    end
    while (drop_done < drop_req) begin
      if (fq.size() > 0) w = fq.pop_front();
      drop_done++;
    end
    while (wr_done < wr_req) begin
      fq.push_back(wr_words[wr_done % 64]);
      wr_done++;
    end
    fifo_count <= 5'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [23:0] w);
    wr_words[wr_req % 64] = w;
    wr_req++;
  endtask

  task automatic expect_word(input logic [23:0] w, input logic l);
    exp_data[exp_wr % 64] = w;
    exp_last[exp_wr % 64] = l;
    exp_wr++;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!((busy == 1'b0) && (exp_rd == exp_wr)) && (n < max)) begin
      tick();
      n++;
    end
    check(name, 32'(n < max), 32'd1);
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && m_valid) begin
          check("hold_data", 32'(m_data), 32'(prev_data));
          check("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          if (exp_rd == exp_wr) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h expected none", m_data);
          end else begin
            check("stream_data", 32'(m_data), 32'(exp_data[exp_rd % 64]));
            check("stream_last", 32'(m_last), 32'(exp_last[exp_rd % 64]));
            exp_rd++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  endtask

  initial begin
    int run;
    int cyc;
    int cnt;
    n_reset = 1'b0;
    m_ready = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    n_reset = 1'b1;
    tick();

    // Full burst with no back-pressure
    m_ready = 1'b1;
    fifo_write(24'hA0000A); expect_word(24'hA0000A, 1'b0);
    fifo_write(24'hB0000B); expect_word(24'hB0000B, 1'b0);
    fifo_write(24'hC0000C); expect_word(24'hC0000C, 1'b0);
    fifo_write(24'hD0000D); expect_word(24'hD0000D, 1'b1);
    cyc = 0;
    while (!fifo_rd_en && (cyc < 20)) begin
      tick();
      cyc++;
    end
    run = 0;
    while (fifo_rd_en && (run < 10)) begin
      run++;
      tick();
    end
    check("full_rd_run", 32'(run), 32'd4);
    wait_done("full_done", 50);
    check("full_count", 32'(fifo_count), 32'd0);
    check("full_err", 32'(err), 32'd0);

    // Timeout flush of a 2-word partial fill
    fifo_write(24'h11EEEE); expect_word(24'h11EEEE, 1'b0);
    fifo_write(24'h22FFFF); expect_word(24'h22FFFF, 1'b1);
    tick();
    cyc = 0;
    while (!fifo_rd_en && (cyc < 40)) begin
      tick();
      cyc++;
    end
    check("timeout_latency", 32'(cyc), 32'd16);
    wait_done("timeout_done", 50);
    check("timeout_count", 32'(fifo_count), 32'd0);

    // Back-pressure: only two reads fit in the buffer
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fifo_write(24'h300000 + 24'(i));
      expect_word(24'h300000 + 24'(i), (i == 3) || (i == 7));
    end
    cnt = 0;
    repeat (10) begin
      tick();
      if (fifo_rd_en) cnt++;
    end
    check("bp_reads", 32'(cnt), 32'd2);
    check("bp_count", 32'(fifo_count), 32'd6);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head", 32'(m_data), 32'h300000);
    m_ready = 1'b1;
    wait_done("bp_done", 100);
    check("bp_final_count", 32'(fifo_count), 32'd0);

    // Ready toggling during a 4-word burst
    for (int i = 0; i < 4; i++) begin
      fifo_write(24'h400000 + 24'(i));
      expect_word(24'h400000 + 24'(i), i == 3);
    end
    cyc = 0;
    while (!((busy == 1'b0) && (exp_rd == exp_wr) && (cyc > 2)) && (cyc < 100)) begin
      m_ready = ~m_ready;
      tick();
      cyc++;
    end
    check("toggle_done", 32'(cyc < 100), 32'd1);
    check("toggle_err", 32'(err), 32'd0);

    // Underflow stall: FIFO emptied externally after the first read
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(24'h500000 + 24'(i));
    expect_word(24'h500000, 1'b0);
    tick();
    tick();
    check("stall_rd_start", 32'(fifo_rd_en), 32'd1);
    drop_req = drop_req + 3;
    tick();
    check("stall_rd_off", 32'(fifo_rd_en), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check("stall_rd_held", 32'(fifo_rd_en), 32'd0);
    check("stall_busy_held", 32'(busy), 32'd1);
    check("stall_err", 32'(err), 32'd0);
    for (int i = 1; i < 4; i++) begin
      fifo_write(24'h600000 + 24'(i));
      expect_word(24'h600000 + 24'(i), i == 3);
    end
    wait_done("stall_done", 60);
    check("stall_err_end", 32'(err), 32'd0);

    // Reset with two words buffered; the remaining two flush after timeout
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(24'h700000 + 24'(i));
    expect_word(24'h700002, 1'b0);
    expect_word(24'h700003, 1'b1);
    repeat (6) tick();
    check("mid_valid", 32'(m_valid), 32'd1);
    n_reset = 1'b0;
    tick();
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    n_reset = 1'b1;
    m_ready = 1'b1;
    wait_done("mid_restart_done", 100);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_err", 32'(err), 32'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
